fir_tap_sequencer: RTL and testbench

Front-end feeder for the microprogrammed FIR datapath. It accepts input samples over a valid/ready stream and keeps them in a circular delay line. It holds a host-writable coefficient RAM. For every accepted sample it emits one (sample, coefficient) pair per tap to the downstream multiply-accumulate engine, over a valid/ready tap stream that carries first/last frame markers.

---
 rtl/fir_tap_sequencer.sv | 138 +++++++++++++
 tb/tb_fir_tap_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: feeds one (sample, coefficient) pair per tap to a MAC engine for every accepted sample.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset (starts a RAM clear sweep)
//   n_taps            tap count latched on sample accept; 0 acts as 1, values above MAX_TAPS act as MAX_TAPS
//   coef_we/addr/wdata host coefficient write, honoured only while idle
//   coef_err          one-cycle pulse the cycle after a write attempted while not idle
//   s_valid/s_ready/s_data                          input sample stream
//   t_valid/t_ready/t_data/t_coeff/t_first/t_last   tap stream, x[n-k] with h[k]
//   busy              high whenever the sequencer is not idle
// Build option FIR_SEQ_ZERO_SKIP_EN: taps with a zero coefficient are not presented, except the last one.
module fir_tap_sequencer #(
    parameter int MAX_TAPS = 256,
    parameter int DW = 8,
    parameter int CW = 8,
    localparam int AW = $clog2(MAX_TAPS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW:0]   n_taps,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_wdata,
    output logic          coef_err,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          t_valid,
    input  logic          t_ready,
    output logic [DW-1:0] t_data,
    output logic [CW-1:0] t_coeff,
    output logic          t_first,
    output logic          t_last,
    output logic          busy
);
    typedef enum logic [1:0] {CLEAR, IDLE, FETCH, ISSUE} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] clr_q, clr_d, wr_q, wr_d, k_q, k_d;
    logic [AW:0] n_q, n_d, n_clamp;
    logic first_q, first_d;
    logic [DW-1:0] t_data_q;
    logic [CW-1:0] t_coeff_q;
    logic coef_err_q;
    logic [DW-1:0] data_mem [MAX_TAPS];
    logic [CW-1:0] coef_mem [MAX_TAPS];
    logic last_tap, skip;

    assign n_clamp = n_taps == '0 ? (AW+1)'(1) :
                     n_taps > (AW+1)'(MAX_TAPS) ? (AW+1)'(MAX_TAPS) : n_taps;
    assign last_tap = {1'b0, k_q} == n_q - (AW+1)'(1);
`ifdef FIR_SEQ_ZERO_SKIP_EN
    assign skip = state_q == ISSUE && t_coeff_q == '0 && !last_tap;
`else
    assign skip = 1'b0;
`endif
    assign s_ready  = state_q == IDLE;
    assign busy     = state_q != IDLE;
    assign t_valid  = state_q == ISSUE && !skip;
    assign t_data   = t_data_q;
    assign t_coeff  = t_coeff_q;
    assign t_first  = t_valid && first_q;
    assign t_last   = t_valid && last_tap;
    assign coef_err = coef_err_q;

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        wr_d    = wr_q;
        k_d     = k_q;
        n_d     = n_q;
        first_d = first_q;
        case (state_q)
            CLEAR: begin
                clr_d = clr_q + AW'(1);
                if (clr_q == AW'(MAX_TAPS - 1)) state_d = IDLE;
            end
            IDLE: if (s_valid) begin
                n_d     = n_clamp;
                k_d     = '0;
                first_d = 1'b1;
                state_d = FETCH;
            end
            FETCH: state_d = ISSUE;
            ISSUE: if (skip) begin
                // suppressed tap: keep first_q so the next presented tap is marked first
                k_d     = k_q + AW'(1);
                state_d = FETCH;
            end else if (t_ready) begin
                first_d = 1'b0;
                if (last_tap) begin
                    wr_d    = wr_q + AW'(1);
                    state_d = IDLE;
                end else begin
                    k_d     = k_q + AW'(1);
                    state_d = FETCH;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // RAM write port: clear sweep, sample insert and host coefficient writes are mutually exclusive by state
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            data_mem[clr_q] <= '0;
            coef_mem[clr_q] <= '0;
        end else if (state_q == IDLE) begin
            if (s_valid) data_mem[wr_q] <= s_data;
            if (coef_we) coef_mem[coef_addr] <= coef_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_q      <= '0;
            wr_q       <= '0;
            k_q        <= '0;
            n_q        <= (AW+1)'(1);
            first_q    <= 1'b0;
            t_data_q   <= '0;
            t_coeff_q  <= '0;
            coef_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            wr_q       <= wr_d;
            k_q        <= k_d;
            n_q        <= n_d;
            first_q    <= first_d;
            coef_err_q <= coef_we && state_q != IDLE;
            // newest sample sits at wr_q, so tap k reads wr_q - k with natural modulo wrap
            if (state_q == FETCH) begin
                t_data_q  <= data_mem[wr_q - k_q];
                t_coeff_q <= coef_mem[k_q];
            end
        end
    end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: table-driven and randomized check of fir_tap_sequencer against a delay-line model.
// Ports: none (self-contained bench). Honours FIR_SEQ_ZERO_SKIP_EN to match the DUT build.
module tb_fir_tap_sequencer;
`ifdef FIR_SEQ_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [8:0] n_taps = '0;
    logic coef_we = 1'b0;
    logic [7:0] coef_addr = '0;
    logic [7:0] coef_wdata = '0;
    logic coef_err, s_ready, t_valid, t_first, t_last, busy;
    logic s_valid = 1'b0;
    logic t_ready = 1'b0;
    logic [7:0] s_data = '0;
    logic [7:0] t_data, t_coeff;
    int pass_cnt = 0;
    int total_cnt = 0;
    int err_cnt = 0;
    logic [7:0] hist [256];
    logic [7:0] cf [256];
    int mwr = 0;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] c;
        int k;
        logic last;
    } tap_t;

    typedef struct {
        logic [7:0] smp;
        logic [8:0] nt;
        int cnt;
        logic [7:0] fd, fc, ld, lc;
    } vec_t;

    fir_tap_sequencer dut (
        .clk(clk), .reset(reset), .n_taps(n_taps),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .t_valid(t_valid), .t_ready(t_ready), .t_data(t_data), .t_coeff(t_coeff),
        .t_first(t_first), .t_last(t_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (coef_err) err_cnt++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_ready;
        int n = 0;
        while (!s_ready && n < 1000) begin
            tick;
            n++;
        end
        check("s_ready_wait", s_ready, 1);
    endtask

    task automatic reset_dut;
        int n = 0;
        reset = 1'b1;
        s_valid = 1'b0;
        coef_we = 1'b0;
        t_ready = 1'b0;
        tick;
        reset = 1'b0;
        check("rst_t_valid", t_valid, 0);
        check("rst_t_data", t_data, 0);
        check("rst_t_coeff", t_coeff, 0);
        check("rst_t_first", t_first, 0);
        check("rst_t_last", t_last, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_coef_err", coef_err, 0);
        check("rst_busy", busy, 1);
        for (int i = 0; i < 256; i++) begin
            hist[i] = '0;
            cf[i] = '0;
        end
        mwr = 0;
        while (!s_ready && n < 300) begin
            tick;
            n++;
        end
        check("clear_cycles", n, 256);
        check("busy_after_clear", busy, 0);
    endtask

    task automatic write_coef(input logic [7:0] a, input logic [7:0] d);
        wait_ready;
        coef_we = 1'b1;
        coef_addr = a;
        coef_wdata = d;
        tick;
        coef_we = 1'b0;
        cf[a] = d;
        check("coef_err_idle", coef_err, 0);
    endtask

    // mode 0: always ready; 1: random ready; 2: 5-cycle stall on 2nd tap;
    // 3: illegal coef write during 1st tap; 4: coef[1]=77 written in the accept cycle
    task automatic run_frame(input logic [7:0] smp, input logic [8:0] nt, input int mode, output int cnt,
                             output logic [7:0] fd, output logic [7:0] fc, output logic [7:0] ld, output logic [7:0] lc);
        tap_t q[$];
        tap_t t;
        int nn, since, budget, prevk, stall, e0;
        logic held;
        logic [7:0] hd, hc;
        logic hf, hl;
        fd = '0; fc = '0; ld = '0; lc = '0;
        hd = '0; hc = '0; hf = 1'b0; hl = 1'b0;
        wait_ready;
        if (mode == 4) begin
            coef_we = 1'b1;
            coef_addr = 8'd1;
            coef_wdata = 8'd77;
            cf[1] = 8'd77;
        end
        hist[mwr] = smp;
        nn = nt == 0 ? 1 : nt > 256 ? 256 : int'(nt);
        for (int k = 0; k < nn; k++) begin
            if (!(SKIP && cf[k] == 0 && k != nn - 1)) begin
                t.d = hist[(mwr - k) & 255];
                t.c = cf[k];
                t.k = k;
                t.last = k == nn - 1;
                q.push_back(t);
            end
        end
        mwr = (mwr + 1) % 256;
        s_valid = 1'b1;
        s_data = smp;
        n_taps = nt;
        tick;
        s_valid = 1'b0;
        coef_we = 1'b0;
        n_taps = 9'($urandom);
        e0 = err_cnt;
        since = 1; prevk = -1; held = 1'b0; cnt = 0; stall = 0; budget = 0;
        while (q.size() > 0 && budget < 2000) begin
            coef_we = 1'b0;
            if (t_valid) begin
                if (!held) begin
                    check("tap_latency", since, 2 * (q[0].k - prevk));
                    check("tap_data", t_data, q[0].d);
                    check("tap_coeff", t_coeff, q[0].c);
                    check("tap_first", t_first, cnt == 0);
                    check("tap_last", t_last, q[0].last);
                    hd = t_data; hc = t_coeff; hf = t_first; hl = t_last;
                    held = 1'b1;
                    if (cnt == 0) begin
                        fd = t_data;
                        fc = t_coeff;
                    end
                    if (mode == 3 && cnt == 0) begin
                        coef_we = 1'b1;
                        coef_addr = 8'd0;
                        coef_wdata = 8'd9;
                    end
                end else begin
                    check("hold_data", t_data, hd);
                    check("hold_coeff", t_coeff, hc);
                    check("hold_first", t_first, hf);
                    check("hold_last", t_last, hl);
                end
                t_ready = mode == 1 ? $urandom_range(0, 2) != 0 : mode == 2 ? !(cnt == 1 && stall < 5) : 1'b1;
                if (!t_ready) stall++;
                if (t_ready) begin
                    ld = t_data;
                    lc = t_coeff;
                    prevk = q[0].k;
                    void'(q.pop_front());
                    cnt++;
                    held = 1'b0;
                    since = 0;
                end
            end else begin
                if (held) check("valid_held", t_valid, 1);
                t_ready = 1'($urandom_range(0, 1));
            end
            tick;
            since++;
            budget++;
        end
        coef_we = 1'b0;
        check("frame_done", q.size(), 0);
        check("s_ready_after_last", s_ready, 1);
        check("t_valid_after_last", t_valid, 0);
        if (mode == 2) check("stall_cycles", stall, 5);
        tick;
        check("coef_err_pulses", err_cnt - e0, mode == 3 ? 1 : 0);
    endtask

    initial begin
        vec_t tbl[5];
        int cnt;
        logic [7:0] fd, fc, ld, lc;
        tbl[0] = '{8'd10, 9'd3, 3, 8'd10, 8'd1, 8'd0, 8'd3};
        tbl[1] = '{8'd20, 9'd3, 3, 8'd20, 8'd1, 8'd0, 8'd3};
        tbl[2] = '{8'd30, 9'd0, 1, 8'd30, 8'd1, 8'd30, 8'd1};
        tbl[3] = '{8'd40, 9'd2, 2, 8'd40, 8'd1, 8'd30, 8'd2};
        tbl[4] = '{8'd50, 9'd300, SKIP ? 4 : 256, 8'd50, 8'd1, 8'd0, 8'd0};
        tick;
        reset_dut;
        write_coef(8'd0, 8'd1);
        write_coef(8'd1, 8'd2);
        write_coef(8'd2, 8'd3);
        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].smp, tbl[i].nt, 0, cnt, fd, fc, ld, lc);
            check("tbl_count", cnt, tbl[i].cnt);
            check("tbl_first_data", fd, tbl[i].fd);
            check("tbl_first_coeff", fc, tbl[i].fc);
            check("tbl_last_data", ld, tbl[i].ld);
            check("tbl_last_coeff", lc, tbl[i].lc);
        end
        run_frame(8'd60, 9'd3, 2, cnt, fd, fc, ld, lc);
        check("bp_count", cnt, 3);
        check("bp_first_data", fd, 60);
        check("bp_last_data", ld, 40);
        run_frame(8'd70, 9'd3, 3, cnt, fd, fc, ld, lc);
        run_frame(8'd80, 9'd1, 0, cnt, fd, fc, ld, lc);
        check("coef0_kept", fc, 1);
`ifdef FIR_SEQ_ZERO_SKIP_EN
        write_coef(8'd0, 8'd0);
        write_coef(8'd1, 8'd5);
        write_coef(8'd2, 8'd0);
        run_frame(8'd90, 9'd3, 0, cnt, fd, fc, ld, lc);
        check("skip_count", cnt, 2);
        check("skip_first_data", fd, 80);
        check("skip_first_coeff", fc, 5);
        check("skip_last_data", ld, 70);
        check("skip_last_coeff", lc, 0);
`endif
        run_frame(8'd100, 9'd3, 4, cnt, fd, fc, ld, lc);
        for (int a = 0; a < 8; a++) write_coef(8'(a), $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom));
        for (int i = 0; i < 30; i++) run_frame(8'($urandom), 9'($urandom_range(0, 12)), 1, cnt, fd, fc, ld, lc);
        for (int a = 0; a < 4; a++) write_coef(8'(a), 8'(a + 1));
        for (int i = 1; i <= 258; i++) begin
            run_frame(8'(i), 9'd4, 0, cnt, fd, fc, ld, lc);
            if (i >= 4) begin
                check("wrap_newest", fd, i & 255);
                check("wrap_oldest", ld, (i - 3) & 255);
            end
        end
        wait_ready;
        s_valid = 1'b1;
        s_data = 8'hAA;
        n_taps = 9'd3;
        t_ready = 1'b0;
        tick;
        s_valid = 1'b0;
        tick;
        check("pre_reset_valid", t_valid, 1);
        reset_dut;
        run_frame(8'h55, 9'd2, 0, cnt, fd, fc, ld, lc);
        check("post_reset_count", cnt, SKIP ? 1 : 2);
        check("post_reset_last_data", ld, 0);
        check("post_reset_last_coeff", lc, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
